// File: rtl/counter_window_sched_if.sv
// rtl/counter_window_sched_if.sv - requester and counter signal bundle for counter_window_sched
// Ports (through modports):
//   req/start/abort  requester side into the scheduler
//   gnt/done/aborted/busy/owner  scheduler status back to requesters
//   cnt_load/cnt_init  scheduler to the shared counter; cnt_out  counter back to scheduler
// master: requester agents plus the shared counter; slave: the scheduler.
interface counter_window_sched_if #(
    parameter int N  = 4,
    parameter int W  = 4,
    parameter int IW = $clog2(N)
);
    logic [N-1:0]   req;
    logic [N*W-1:0] start;
    logic           abort;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           aborted;
    logic           busy;
    logic [IW-1:0]  owner;
    logic           cnt_load;
    logic [W-1:0]   cnt_init;
    logic [W-1:0]   cnt_out;

    modport master (
        output req, start, abort, cnt_out,
        input  gnt, done, aborted, busy, owner, cnt_load, cnt_init
    );

    modport slave (
        input  req, start, abort, cnt_out,
        output gnt, done, aborted, busy, owner, cnt_load, cnt_init
    );
endinterface

// File: rtl/counter_window_sched.sv
// rtl/counter_window_sched.sv - round-robin scheduler sharing one wrapping counter among N requesters
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (also resets the external counter)
//   s    slave side of counter_window_sched_if: req/start/abort in, gnt/done/aborted/busy/owner out,
//        cnt_load/cnt_init to the shared counter, cnt_out from it
// Each grant runs one window: LOAD the owner's start value, RUN until the counter
// reaches all-ones (or abort), pulse done, then rearbitrate from IDLE.
module counter_window_sched #(
    parameter int N  = 4,
    parameter int W  = 4,
    parameter int IW = $clog2(N)
) (
    input logic                   clk,
    input logic                   rst,
    counter_window_sched_if.slave s
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;

    logic [N-1:0]   gnt_q;
    logic [N-1:0]   done_q;
    logic           aborted_q;
    logic           busy_q;
    logic [IW-1:0]  owner_q;
    logic           cnt_load_q;
    logic [W-1:0]   cnt_init_q;

    // The request vector is doubled so the round-robin search from ptr+1 never
    // needs a modulo on a non-power-of-two N.
    logic [2*N-1:0] req2;
    logic [IW:0]    j;
    logic           pick_valid;
    logic [IW-1:0]  pick;
    logic [W-1:0]   pick_start;

    assign req2 = {s.req, s.req};

    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        j          = '0;
        // Search farthest first so the nearest set bit after ptr wins last.
        for (int k = N; k >= 1; k--) begin
            j = {1'b0, ptr} + (IW+1)'(k);
            if (req2[j]) begin
                pick_valid = 1'b1;
                pick       = (j >= (IW+1)'(N)) ? IW'(j - (IW+1)'(N)) : IW'(j);
            end
        end
    end

    always_comb begin
        pick_start = '0;
        for (int i = 0; i < N; i++) begin
            if (pick == IW'(i)) begin
                pick_start = s.start[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= IW'(N-1);
            gnt_q      <= '0;
            done_q     <= '0;
            aborted_q  <= 1'b0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            cnt_load_q <= 1'b0;
            cnt_init_q <= '0;
        end else begin
            gnt_q      <= '0;
            done_q     <= '0;
            cnt_load_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q    <= pick;
                        ptr        <= pick;
                        cnt_init_q <= pick_start;
                        gnt_q      <= N'(1) << pick;
                        cnt_load_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= LOAD;
                    end
                end
                // Abort is deliberately not looked at here; the load always lands.
                LOAD: begin
                    state <= RUN;
                end
                RUN: begin
                    // Abort outranks terminal count so a coincident abort is reported.
                    if (s.abort) begin
                        aborted_q <= 1'b1;
                        done_q    <= N'(1) << owner_q;
                        state     <= DONE;
                    end else if (s.cnt_out == '1) begin
                        done_q <= N'(1) << owner_q;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    aborted_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign s.gnt      = gnt_q;
    assign s.done     = done_q;
    assign s.aborted  = aborted_q;
    assign s.busy     = busy_q;
    assign s.owner    = owner_q;
    assign s.cnt_load = cnt_load_q;
    assign s.cnt_init = cnt_init_q;
endmodule

// File: doc/counter_window_sched.md
Name: counter_window_sched

Overview:
- Round-robin scheduler that shares one loadable W-bit wrapping counter (clk/rst/load/init/out style) among N requesters.
- Each granted requester owns the counter for one "window":
  - the scheduler loads the requester's start value;
  - the counter free-runs until it reaches all-ones and wraps;
  - the scheduler then signals done and rearbitrates.
- Sits between requester agents and the counter instance; the counter is instantiated outside this block.

Parameters:
- N, 4, number of requesters (2..8)
- W, 4, counter width; must equal the shared counter's width
- IW, $clog2(N), width of owner index

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high; also drives the shared counter's rst
- req  in  N  level request per requester; held until gnt seen, then may drop
- start  in  N*W  per-requester start value; slice i = start[i*W +: W]; sampled at arbitration
- abort  in  1  terminates current window early
- gnt  out  N  one-hot, one-cycle pulse: request accepted
- done  out  N  one-hot, one-cycle pulse: owner's window ended
- aborted  out  1  high with done when window ended by abort
- busy  out  1  high in LOAD/RUN/DONE
- owner  out  IW  index of current/last owner
- cnt_load  out  1  to counter load
- cnt_init  out  W  to counter init
- cnt_out  in  W  from counter out

Behaviour:
- All outputs decode only from registers; there is no combinational input-to-output path.
- Reset: asynchronous, from any state.
  - State returns to IDLE.
  - gnt=0, done=0, aborted=0, busy=0, cnt_load=0, cnt_init=0, owner=0.
  - RR pointer = N-1, so requester 0 wins first.
  - An in-flight window is discarded with no done pulse.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req bit is set, select the first set bit searching from ptr+1 upward, modulo N.
  - Register owner and ptr = winner; latch start slice into cnt_init; go to LOAD.
  - If no req is set, stay in IDLE.
- LOAD (exactly 1 cycle):
  - gnt[owner]=1, cnt_load=1, cnt_init=latched start; go to RUN.
  - Counter shows the start value in the first RUN cycle.
- RUN:
  - cnt_load=0; cnt_init holds the latched value.
  - If abort=1, go to DONE with aborted flag set.
  - Else if cnt_out == all-ones, go to DONE. The counter wraps to 0 on the same edge.
  - Else stay in RUN.
  - Abort and terminal count in the same cycle: abort wins, so aborted=1.
- LOAD with abort=1: abort is ignored. The load completes and abort is re-sampled in RUN.
- DONE (exactly 1 cycle):
  - done[owner]=1; aborted = registered flag; busy=1; go to IDLE.
  - The aborted flag clears on leaving DONE.
- Window timing, grant decision registered at edge t:
  - LOAD cycle: t+1
  - RUN: t+2 .. t+2+(2^W - start) - 1
  - DONE: next cycle, then IDLE
  - RUN length = 2^W - start cycles.
  - start = all-ones gives 1 RUN cycle; start = 0 gives 2^W RUN cycles.
- Minimum gap between windows is one IDLE cycle. Grant-to-grant spacing is at least 2^W - start + 3 cycles.
- req changes:
  - req dropped before arbitration: not granted.
  - req changes while busy: ignored until the next IDLE.
  - Owner re-asserting req during DONE: eligible, but ranks last in RR order.
- Fairness: with all N requesting continuously, grants rotate 0,1,..,N-1,0,...
- cnt_out is not checked for consistency. The block assumes nothing else drives counter load.

Test Plan:
- Reset then req=0001, start[0]=12 → gnt[0] at cycle 1 with cnt_load=1, cnt_init=12; RUN sees cnt_out 12,13,14,15; done[0] one cycle later with cnt_out=0; busy low next cycle.
- req=1111 held, all starts=14 → grant order 0,1,2,3,0; each grant-to-grant spacing 2+3=5 cycles; owner matches gnt index.
- start[2]=15 only req[2] → single RUN cycle; done[2] 2 cycles after gnt; start[1]=0 → RUN lasts 16 cycles.
- abort asserted in 3rd RUN cycle (start=5) → done and aborted=1 next cycle; aborted=0 afterwards. Abort during LOAD → ignored; window runs normally if abort drops.
- Abort coincident with cnt_out=15 → done with aborted=1; rst asserted mid-RUN → all outputs 0 immediately with no done; next req=0100 granted to requester 2, since ptr is reset to N-1.
- req[1] pulsed for 1 cycle while busy, dropped before IDLE → never granted; X-check: no X on any output after reset release.
